// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and types for the 4-way bus arbiter.
package arb_pkg;
  localparam int NREQ = 4;
  typedef enum logic {IDLE, OWN} state_t;
  typedef logic [1:0] idx_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin picker, first active request at or after ptr.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  idx_t            ptr,
  output logic            valid,
  output idx_t            idx
);
  // Scan from farthest to nearest so the nearest active request overwrites the rest.
  always_comb begin
    valid = 1'b0;
    idx = ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[idx_t'(ptr + idx_t'(i))]) begin
        valid = 1'b1;
        idx = idx_t'(ptr + idx_t'(i));
      end
  end
endmodule

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: 4-requester round-robin arbiter with registered one-hot grant.
// Define ARB_TIMEOUT_EN to bound ownership to HOLD_MAX cycles with a timeout pulse.
module bus_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output idx_t            sel,
  output logic            busy,
  output logic            timeout
);
  state_t state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  idx_t sel_q, sel_d, ptr_q, ptr_d, pick_idx;
  logic pick_valid, rel, lim;
  rr_pick4 u_pick (.req(req), .ptr(ptr_q), .valid(pick_valid), .idx(pick_idx));
  assign rel = done | ~req[sel_q];
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic to_q, to_d;
  assign lim = (state_q == OWN) && (cnt_q == CNT_W'(HOLD_MAX - 1));
  // A normal release on the limit edge takes precedence over the forced one.
  always_comb begin
    cnt_d = (state_q == OWN) ? cnt_q + 1'b1 : '0;
    to_d = lim & ~rel;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  end
  assign timeout = to_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_MAX, CNT_W};
  assign lim = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    if (state_q == IDLE) begin
      if (pick_valid) begin
        state_d = OWN;
        gnt_d = NREQ'(1) << pick_idx;
        sel_d = pick_idx;
        ptr_d = pick_idx + 2'd1;
      end
    end else if (rel | lim) begin
      state_d = IDLE;
      gnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end
  assign gnt = gnt_q;
  assign sel = sel_q;
  assign busy = |gnt_q;
endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed and random checks of bus_arbiter4 against an ownership model.
module tb_bus_arbiter4;
  localparam int HM = 4;
  logic clk = 1'b0, rst_n = 1'b0, done = 1'b0;
  logic [3:0] req = '0, gnt;
  logic [1:0] sel;
  logic busy, timeout;
  int checks = 0, errs = 0;
  int m_own = -1, m_last = 0, m_ptr = 0, m_hold = 0;
  bit m_to = 1'b0;

  bus_arbiter4 #(.HOLD_MAX(HM), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference: who owns the bus, for how many cycles, and who is next in line.
  function automatic void model(bit rn, logic [3:0] rq, bit dn);
    if (!rn) begin
      m_own = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    end else if (m_own < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 4; k++)
        if (m_own < 0 && rq[(m_ptr + k) % 4]) begin
          m_own = (m_ptr + k) % 4;
          m_last = m_own;
          m_ptr = (m_own + 1) % 4;
          m_hold = 1;
        end
    end else if (dn || !rq[m_own]) begin
      m_own = -1;
      m_to = 1'b0;
    end
`ifdef ARB_TIMEOUT_EN
    else if (m_hold == HM) begin
      m_own = -1;
      m_to = 1'b1;
    end
`endif
    else m_hold++;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(bit rn, logic [3:0] rq, bit dn);
    rst_n = rn; req = rq; done = dn;
    @(posedge clk);
    model(rn, rq, dn);
    #1;
    chk("gnt", gnt, m_own < 0 ? 0 : 1 << m_own);
    chk("sel", sel, m_last);
    chk("busy", busy, m_own >= 0);
    chk("timeout", timeout, m_to);
  endtask

  initial begin
    cyc(0, 4'b0000, 0);
    cyc(0, 4'b1111, 0);
    chk("reset_gnt", gnt, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 4'b1111, 0);
      chk("rr_order", gnt, 1 << (i % 4));
      cyc(1, 4'b1111, 1);
      chk("rr_gap", gnt, 0);
    end
    cyc(1, 4'b0100, 0);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_sel", sel, 2);
    cyc(1, 4'b0100, 1);
    cyc(1, 4'b0100, 0);
    cyc(1, 4'b0000, 0);
    chk("withdraw_gnt", gnt, 0);
    chk("withdraw_sel", sel, 2);
    cyc(1, 4'b0010, 0);
    cyc(1, 4'b1010, 0);
    cyc(1, 4'b1010, 0);
    chk("no_preempt", gnt, 4'b0010);
    cyc(1, 4'b1010, 1);
    cyc(1, 4'b1000, 0);
    chk("next_owner", gnt, 4'b1000);
    cyc(1, 4'b1000, 1);
    cyc(1, 4'b0001, 0);
    chk("own0", gnt, 4'b0001);
    cyc(0, 4'b0001, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel, 0);
    cyc(1, 4'b0001, 0);
    chk("post_rst", gnt, 4'b0001);
    cyc(1, 4'b0001, 1);
    for (int i = 0; i < 8; i++) cyc(1, 4'b0011, 0);
    cyc(1, 4'b0011, 1);
    cyc(1, 4'b0000, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 49) != 0, 4'($urandom), $urandom_range(0, 3) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
